ps2_key_ctrl: RTL and testbench

Scan-code controller between the PS/2 byte receiver and the breakout game logic. Consumes the receiver's completed-byte strobe stream (scan code set 2), sequences the E0/F0 prefix protocol, tracks make/break state of the game keys, and converts it into paddle step pulses, debounced one-shot commands and a sequence-error flag. The game core reads only this block's outputs, never raw scan codes.

---
 rtl/ps2_key_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_ps2_key_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_ctrl.sv
// PS/2 scan-code set 2 controller for the breakout game: sequences E0/F0 prefixes,
// tracks game-key make/break state and produces paddle steps and one-shot commands.
module ps2_key_ctrl #(
  parameter int unsigned STEP_DIV    = 500000,
  parameter int unsigned PFX_TIMEOUT = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic       held_left,
  output logic       held_right,
  output logic       step_left,
  output logic       step_right,
  output logic       launch,
  output logic       pause_tgl,
  output logic       restart,
  output logic       seq_err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXT     = 2'd1,
    S_BRK     = 2'd2,
    S_EXT_BRK = 2'd3
  } state_e;

  localparam int K_LARROW = 0;
  localparam int K_A      = 1;
  localparam int K_RARROW = 2;
  localparam int K_D      = 3;
  localparam int K_SPACE  = 4;
  localparam int K_P      = 5;
  localparam int K_ESC    = 6;

  localparam logic [7:0]  B_EXT     = 8'hE0;
  localparam logic [7:0]  B_BRK     = 8'hF0;
  localparam logic [19:0] STEP_LAST = 20'(STEP_DIV - 1);
  localparam logic [19:0] PFX_LAST  = 20'(PFX_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [6:0]  keys_q, keys_d;
  logic [19:0] pfx_cnt_q, pfx_cnt_d;
  logic [19:0] step_cnt_q, step_cnt_d;
  logic [1:0]  dir_q, dir_d;
  logic        held_left_q, held_left_d;
  logic        held_right_q, held_right_d;
  logic        step_left_q, step_left_d;
  logic        step_right_q, step_right_d;
  logic        launch_q, launch_d;
  logic        pause_q, pause_d;
  logic        restart_q, restart_d;
  logic        seq_err_q, seq_err_d;
  logic        overrun, pfx_expire;
  logic        act_left, act_right, nxt_left, nxt_right, step_due;

  // Prefix, ack, self-test and E1 bytes map to an empty mask, so they never touch key state.
  function automatic logic [6:0] key_mask(input logic ext, input logic [7:0] code);
    logic [6:0] m;
    m = '0;
    if (ext) begin
      if (code == 8'h6B) m[K_LARROW] = 1'b1;
      if (code == 8'h74) m[K_RARROW] = 1'b1;
    end else begin
      case (code)
        8'h1C:   m[K_A]     = 1'b1;
        8'h23:   m[K_D]     = 1'b1;
        8'h29:   m[K_SPACE] = 1'b1;
        8'h4D:   m[K_P]     = 1'b1;
        8'h76:   m[K_ESC]   = 1'b1;
        default: m = '0;
      endcase
    end
    return m;
  endfunction

  assign overrun    = rx_valid && (rx_byte == 8'h00 || rx_byte == 8'hFF);
  assign pfx_expire = !rx_valid && (state_q != S_IDLE) && (pfx_cnt_q == PFX_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (overrun || pfx_expire) begin
      state_d = S_IDLE;
    end else if (rx_valid) begin
      unique case (state_q)
        S_IDLE: begin
          if (rx_byte == B_EXT)      state_d = S_EXT;
          else if (rx_byte == B_BRK) state_d = S_BRK;
        end
        S_EXT:   state_d = (rx_byte == B_BRK) ? S_EXT_BRK : S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    keys_d    = keys_q;
    seq_err_d = overrun || pfx_expire;
    if (overrun) begin
      keys_d = '0;
    end else if (rx_valid) begin
      unique case (state_q)
        S_IDLE:  keys_d = keys_q | key_mask(1'b0, rx_byte);
        S_EXT:   keys_d = keys_q | key_mask(1'b1, rx_byte);
        S_BRK:   keys_d = keys_q & ~key_mask(1'b0, rx_byte);
        default: keys_d = keys_q & ~key_mask(1'b1, rx_byte);
      endcase
    end
    held_left_d  = keys_d[K_LARROW] | keys_d[K_A];
    held_right_d = keys_d[K_RARROW] | keys_d[K_D];
    launch_d     = keys_d[K_SPACE] & ~keys_q[K_SPACE];
    pause_d      = keys_d[K_P] & ~keys_q[K_P];
    restart_d    = keys_d[K_ESC] & ~keys_q[K_ESC];
  end

  always_comb begin
    pfx_cnt_d = '0;
    if (!rx_valid && state_q != S_IDLE && !pfx_expire) pfx_cnt_d = pfx_cnt_q + 20'd1;
  end

  // A due step is dropped if the held state is about to leave that direction.
  always_comb begin
    act_left   = held_left_q & ~held_right_q;
    act_right  = held_right_q & ~held_left_q;
    nxt_left   = held_left_d & ~held_right_d;
    nxt_right  = held_right_d & ~held_left_d;
    dir_d      = {act_right, act_left};
    step_due   = 1'b0;
    step_cnt_d = '0;
    if (act_left || act_right) begin
      if (dir_d != dir_q || step_cnt_q == STEP_LAST) step_due = 1'b1;
      else                                            step_cnt_d = step_cnt_q + 20'd1;
    end
    step_left_d  = step_due & act_left & nxt_left;
    step_right_d = step_due & act_right & nxt_right;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      keys_q       <= '0;
      pfx_cnt_q    <= '0;
      step_cnt_q   <= '0;
      dir_q        <= '0;
      held_left_q  <= 1'b0;
      held_right_q <= 1'b0;
      step_left_q  <= 1'b0;
      step_right_q <= 1'b0;
      launch_q     <= 1'b0;
      pause_q      <= 1'b0;
      restart_q    <= 1'b0;
      seq_err_q    <= 1'b0;
    end else begin
      keys_q       <= keys_d;
      pfx_cnt_q    <= pfx_cnt_d;
      step_cnt_q   <= step_cnt_d;
      dir_q        <= dir_d;
      held_left_q  <= held_left_d;
      held_right_q <= held_right_d;
      step_left_q  <= step_left_d;
      step_right_q <= step_right_d;
      launch_q     <= launch_d;
      pause_q      <= pause_d;
      restart_q    <= restart_d;
      seq_err_q    <= seq_err_d;
    end
  end

  assign held_left  = held_left_q;
  assign held_right = held_right_q;
  assign step_left  = step_left_q;
  assign step_right = step_right_q;
  assign launch     = launch_q;
  assign pause_tgl  = pause_q;
  assign restart    = restart_q;
  assign seq_err    = seq_err_q;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Bench for ps2_key_ctrl: byte table, hand-timed corner sequences and a random byte stream
// compared cycle by cycle against a key-set / prefix-queue reference model.
module tb_ps2_key_ctrl;
  localparam int STEP_DIV    = 8;
  localparam int PFX_TIMEOUT = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_valid = 1'b0;
  logic       held_left, held_right, step_left, step_right;
  logic       launch, pause_tgl, restart, seq_err;
  logic [7:0] outs;

  ps2_key_ctrl #(.STEP_DIV(STEP_DIV), .PFX_TIMEOUT(PFX_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .held_left(held_left), .held_right(held_right),
    .step_left(step_left), .step_right(step_right),
    .launch(launch), .pause_tgl(pause_tgl), .restart(restart), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  assign outs = {held_left, held_right, step_left, step_right, launch, pause_tgl, restart, seq_err};

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: every make/break tracked as a set of {ext,code} keys, prefixes kept as a byte queue.
  bit         pressed [512];
  logic [7:0] pfx [$];
  int         last_rx = 0;
  int         run_start = 0;
  logic [7:0] exp_o = 8'h00;

  int step_l_log [$];
  int step_r_log [$];
  int err_log [$];
  int cmd_cnt [3];

  typedef struct {
    logic [7:0] code;
    logic [5:0] exp;
  } vec_t;
  vec_t tbl [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic int dir_of(input bit l, input bit r);
    return (l && !r) ? 1 : ((r && !l) ? 2 : 0);
  endfunction

  task automatic model_clear();
    foreach (pressed[k]) pressed[k] = 1'b0;
    pfx.delete();
    exp_o   = 8'h00;
    last_rx = cyc;
  endtask

  task automatic model_edge(input bit v, input logic [7:0] b);
    bit         ext, brk, nl, nr, sl, sr, la, pa, re, er;
    int         cur, nxt;
    logic [8:0] key;
    la = 0; pa = 0; re = 0; er = 0;
    if (v && (b == 8'h00 || b == 8'hFF)) begin
      foreach (pressed[k]) pressed[k] = 1'b0;
      pfx.delete();
      er = 1;
    end else if (v) begin
      last_rx = cyc;
      if (pfx.size() == 0 && (b == 8'hFA || b == 8'hAA || b == 8'hE1)) begin
      end else if (pfx.size() == 0 && b == 8'hE0) begin
        pfx.push_back(b);
      end else if (b == 8'hF0 && (pfx.size() == 0 || (pfx.size() == 1 && pfx[0] == 8'hE0))) begin
        pfx.push_back(b);
      end else begin
        ext = (pfx.size() > 0) && (pfx[0] == 8'hE0);
        brk = (pfx.size() > 0) && (pfx[pfx.size()-1] == 8'hF0);
        key = {ext, b};
        if (brk) begin
          pressed[key] = 1'b0;
        end else begin
          if (!pressed[key]) begin
            la = (key == 9'h029);
            pa = (key == 9'h04D);
            re = (key == 9'h076);
          end
          pressed[key] = 1'b1;
        end
        pfx.delete();
      end
    end else if (pfx.size() > 0 && (cyc - last_rx) == PFX_TIMEOUT) begin
      pfx.delete();
      er = 1;
    end
    nl  = pressed[9'h16B] | pressed[9'h01C];
    nr  = pressed[9'h174] | pressed[9'h023];
    cur = dir_of(exp_o[7], exp_o[6]);
    nxt = dir_of(nl, nr);
    sl  = (cur == 1) && (nxt == 1) && (((cyc - run_start) % STEP_DIV) == 0);
    sr  = (cur == 2) && (nxt == 2) && (((cyc - run_start) % STEP_DIV) == 0);
    if (nxt != cur) run_start = cyc + 1;
    exp_o = {nl, nr, sl, sr, la, pa, re, er};
  endtask

  // Drive one cycle of input from a negedge, then compare the DUT against the model at the next negedge.
  task automatic tick(input bit v, input logic [7:0] b);
    rx_valid = v;
    rx_byte  = b;
    if (rst) model_edge(v, b);
    else     model_clear();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    rx_valid = 1'b0;
    check($sformatf("cycle %0d outputs", cyc), {24'd0, outs}, {24'd0, exp_o});
    if (step_left)  step_l_log.push_back(cyc);
    if (step_right) step_r_log.push_back(cyc);
    if (seq_err)    err_log.push_back(cyc);
    if (launch)     cmd_cnt[0]++;
    if (pause_tgl)  cmd_cnt[1]++;
    if (restart)    cmd_cnt[2]++;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 8'($urandom));
  endtask

  task automatic send(input logic [7:0] b);
    tick(1'b1, b);
    idle(1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle(2);
    check("reset outputs", {24'd0, outs}, 32'd0);
    rst = 1'b1;
  endtask

  task automatic clear_logs();
    step_l_log.delete();
    step_r_log.delete();
    err_log.delete();
    cmd_cnt = '{0, 0, 0};
  endtask

  initial begin
    int         n;
    logic [7:0] b;
    logic [7:0] pool [7];
    logic [7:0] cmd_codes [3];
    pool      = '{8'h1C, 8'h23, 8'h29, 8'h4D, 8'h76, 8'h6B, 8'h74};
    cmd_codes = '{8'h29, 8'h4D, 8'h76};

    // exp = {held_left, held_right, launch, pause_tgl, restart, seq_err} one cycle after the byte
    tbl.push_back('{8'h1C, 6'b100000});
    tbl.push_back('{8'hF0, 6'b100000});
    tbl.push_back('{8'h1C, 6'b000000});
    tbl.push_back('{8'hE0, 6'b000000});
    tbl.push_back('{8'h6B, 6'b100000});
    tbl.push_back('{8'h23, 6'b110000});
    tbl.push_back('{8'hE0, 6'b110000});
    tbl.push_back('{8'hF0, 6'b110000});
    tbl.push_back('{8'h6B, 6'b010000});
    tbl.push_back('{8'h29, 6'b011000});
    tbl.push_back('{8'h29, 6'b010000});
    tbl.push_back('{8'hF0, 6'b010000});
    tbl.push_back('{8'h29, 6'b010000});
    tbl.push_back('{8'h29, 6'b011000});
    tbl.push_back('{8'h4D, 6'b010100});
    tbl.push_back('{8'h4D, 6'b010000});
    tbl.push_back('{8'h76, 6'b010010});
    tbl.push_back('{8'hE0, 6'b010000});
    tbl.push_back('{8'h1C, 6'b010000});
    tbl.push_back('{8'h6B, 6'b010000});
    tbl.push_back('{8'hFA, 6'b010000});
    tbl.push_back('{8'hAA, 6'b010000});
    tbl.push_back('{8'hE1, 6'b010000});
    tbl.push_back('{8'hF0, 6'b010000});
    tbl.push_back('{8'h23, 6'b000000});
    tbl.push_back('{8'h1C, 6'b100000});
    tbl.push_back('{8'hFF, 6'b000001});

    @(negedge clk);
    do_reset();

    for (int i = 0; i < tbl.size(); i++) begin
      tick(1'b1, tbl[i].code);
      check($sformatf("table[%0d] byte %0h", i, tbl[i].code),
            {26'd0, held_left, held_right, launch, pause_tgl, restart, seq_err}, {26'd0, tbl[i].exp});
      idle(1);
    end

    // Held A: steps at N+2, N+2+D, N+2+2D; none after the break
    do_reset();
    clear_logs();
    n = cyc;
    tick(1'b1, 8'h1C);
    check("A held at N+1", {31'd0, held_left}, 32'd1);
    idle(2 * STEP_DIV + 3);
    check("A step count", step_l_log.size(), 3);
    for (int k = 0; k < 3 && k < step_l_log.size(); k++)
      check($sformatf("A step %0d cycle", k), step_l_log[k], n + 2 + k * STEP_DIV);
    clear_logs();
    send(8'hF0);
    send(8'h1C);
    idle(3 * STEP_DIV);
    check("A released", {31'd0, held_left}, 32'd0);
    check("steps after break", step_l_log.size(), 0);

    // Both directions held: no steps; releasing Left-arrow restarts on the right
    do_reset();
    send(8'hE0); send(8'h6B); send(8'h23);
    clear_logs();
    idle(2 * STEP_DIV);
    check("both held", {30'd0, held_left, held_right}, 32'd3);
    check("no steps when both", step_l_log.size() + step_r_log.size(), 0);
    send(8'hE0); send(8'hF0);
    n = cyc;
    tick(1'b1, 8'h6B);
    idle(3);
    check("right step count", step_r_log.size(), 1);
    if (step_r_log.size() > 0) check("right first step", step_r_log[0], n + 2);

    // Typematic repeats produce one pulse per fresh press
    do_reset();
    clear_logs();
    foreach (cmd_codes[j]) begin
      send(cmd_codes[j]); send(cmd_codes[j]); send(cmd_codes[j]);
      send(8'hF0); send(cmd_codes[j]);
      send(cmd_codes[j]);
    end
    check("launch pulses", cmd_cnt[0], 2);
    check("pause pulses", cmd_cnt[1], 2);
    check("restart pulses", cmd_cnt[2], 2);

    // Prefix timeout, then a bare 6B
    do_reset();
    clear_logs();
    n = cyc;
    tick(1'b1, 8'hE0);
    idle(PFX_TIMEOUT + 3);
    check("timeout pulse count", err_log.size(), 1);
    if (err_log.size() > 0) check("timeout cycle", err_log[0], n + PFX_TIMEOUT + 1);
    tick(1'b1, 8'h6B);
    check("6B after timeout", {31'd0, held_left}, 32'd0);
    idle(1);

    // Overrun byte landing exactly in the expiry cycle
    do_reset();
    clear_logs();
    n = cyc;
    tick(1'b1, 8'hE0);
    idle(PFX_TIMEOUT - 1);
    tick(1'b1, 8'hFF);
    idle(PFX_TIMEOUT + 3);
    check("overrun at expiry count", err_log.size(), 1);
    if (err_log.size() > 0) check("overrun at expiry cycle", err_log[0], n + PFX_TIMEOUT + 1);

    // Overrun clears both directions; ignored bytes change nothing
    do_reset();
    send(8'h1C); send(8'hE0); send(8'h74);
    check("A and Right held", {30'd0, held_left, held_right}, 32'd3);
    clear_logs();
    tick(1'b1, 8'hFF);
    check("overrun clears", {30'd0, held_left, held_right}, 32'd0);
    check("overrun seq_err", {31'd0, seq_err}, 32'd1);
    idle(PFX_TIMEOUT + 2);
    check("overrun single pulse", err_log.size(), 1);
    send(8'h1C);
    foreach (cmd_codes[j]) begin
      b = (j == 0) ? 8'hFA : ((j == 1) ? 8'hAA : 8'hE1);
      tick(1'b1, b);
      check($sformatf("ignored %0h", b),
            {26'd0, held_left, held_right, launch, pause_tgl, restart, seq_err}, 32'h20);
      idle(1);
    end

    // Break of the last direction coinciding with a due step suppresses it
    do_reset();
    clear_logs();
    n = cyc;
    tick(1'b1, 8'h1C);
    idle(2 * STEP_DIV - 2);
    tick(1'b1, 8'hF0);
    idle(1);
    tick(1'b1, 8'h1C);
    check("suppress held", {31'd0, held_left}, 32'd0);
    check("suppress step", {31'd0, step_left}, 32'd0);
    idle(STEP_DIV + 2);
    check("suppress step count", step_l_log.size(), 2);

    // Reset after a stray F0 discards the pending break
    do_reset();
    send(8'h23);
    tick(1'b1, 8'hF0);
    rst = 1'b0;
    idle(3);
    check("outputs in reset", {24'd0, outs}, 32'd0);
    rst = 1'b1;
    idle(1);
    tick(1'b1, 8'h1C);
    check("1C after reset", {30'd0, held_left, held_right}, 32'd2);
    idle(1);

    // Random byte stream against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      n = $urandom_range(0, 99);
      if (n < 8)       b = 8'hE0;
      else if (n < 16) b = 8'hF0;
      else if (n < 70) b = pool[$urandom_range(0, 6)];
      else if (n < 78) b = ($urandom_range(0, 2) == 0) ? 8'hFA : (($urandom_range(0, 1) == 0) ? 8'hAA : 8'hE1);
      else if (n < 80) b = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
      else             b = 8'($urandom);
      tick(1'b1, b);
      if ($urandom_range(0, 9) == 0) idle($urandom_range(PFX_TIMEOUT - 2, PFX_TIMEOUT + 2));
      else                           idle($urandom_range(1, 4));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
